wb_ctrl_client: RTL and testbench

Wishbone-slave-to-byte-stream bridge: the host-side counterpart of the control port. It converts single 32-bit Wishbone accesses into framed command packets on an outgoing byte stream and parses the controller's echoed response (plus read data) from an incoming byte stream. It sits between a local Wishbone master (CPU or test sequencer) and a serial link whose far end is a control-port instance acting as Wishbone master.

---
 rtl/wb_ctrl_client_pkg.sv | 33 +++
 rtl/wb_ctrl_client_crc8_byte.sv | 20 ++
 rtl/wb_ctrl_client.sv | 141 ++++++++++++++
 tb/tb_wb_ctrl_client.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctrl_client_pkg.sv
// Shared definitions for the Wishbone-to-byte-stream control client:
// FSM states, command header layout, CRC polynomial and error data word.
package wb_ctrl_client_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_HDR,
        ST_TX_DATA,
        ST_RX_HDR,
        ST_RX_DATA,
        ST_ACK
    } state_t;

    // Header byte 0 layout: {wr, wsize[1:0], aincr, 4'b0}
    localparam int unsigned B0_WR_BIT    = 7;
    localparam int unsigned B0_WSIZE_LSB = 5;
    localparam int unsigned B0_AINCR_BIT = 4;

    localparam logic [1:0]  WSIZE_32 = 2'b10;
    localparam int unsigned HDR_LEN  = 7;
    localparam logic [7:0]  CRC_POLY = 8'h07;
    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    function automatic logic [7:0] hdr_byte0(input logic wr);
        logic [7:0] b;
        b                          = '0;
        b[B0_WR_BIT]               = wr;
        b[B0_WSIZE_LSB +: 2]       = WSIZE_32;
        b[B0_AINCR_BIT]            = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/wb_ctrl_client_crc8_byte.sv
// Combinational CRC-8 step (poly 0x07, MSB first): folds one byte into a running CRC.
module crc8_byte
    import wb_ctrl_client_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/wb_ctrl_client.sv
// Wishbone slave that frames single-word accesses as command packets on a byte
// stream and parses the echoed header and read data coming back.
module wb_ctrl_client
    import wb_ctrl_client_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 30,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic [31:0]              o_wb_data,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_rx_ready,
    output logic                     o_err_crc,
    output logic                     o_err_timeout
);

    localparam logic [2:0]  HDR_LAST  = 3'(HDR_LEN - 1);
    localparam logic [2:0]  DATA_LAST = 3'd3;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_nx;
    logic [2:0]               idx;
    logic                     we_q;
    logic [WB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]              wdata_q;
    logic [7:0]               crc_q, crc_nx;
    logic                     bad_q;
    logic                     drop_q;
    logic [15:0]              tmo_cnt;

    logic [31:0] addr32;
    logic [7:0]  hdr_cur;
    logic        tx_fire, rx_fire, rx_state, timeout, hdr_miss;

    logic unused_sel;
    assign unused_sel = ^i_wb_sel;

    // CRC accumulates while the header goes out, so byte 6 is ready when idx reaches it
    crc8_byte u_crc (
        .crc_in  (crc_q),
        .data    (hdr_cur),
        .crc_out (crc_nx)
    );

    always_comb begin
        addr32 = 32'(addr_q);
        unique case (idx)
            3'd0:    hdr_cur = hdr_byte0(we_q);
            3'd1:    hdr_cur = 8'h00;
            3'd2:    hdr_cur = addr32[7:0];
            3'd3:    hdr_cur = addr32[15:8];
            3'd4:    hdr_cur = addr32[23:16];
            3'd5:    hdr_cur = addr32[31:24];
            default: hdr_cur = crc_q;
        endcase

        o_wb_stall    = (state != ST_IDLE);
        o_tx_valid    = (state == ST_TX_HDR) || (state == ST_TX_DATA);
        o_tx_data     = (state == ST_TX_DATA) ? wdata_q[{idx[1:0], 3'b000} +: 8] : hdr_cur;
        rx_state      = (state == ST_RX_HDR) || (state == ST_RX_DATA);
        o_rx_ready    = rx_state;
        tx_fire       = o_tx_valid & i_tx_ready;
        rx_fire       = rx_state & i_rx_valid;
        timeout       = rx_state && !rx_fire && (tmo_cnt == TMO_LAST);
        hdr_miss      = (state == ST_RX_HDR) && rx_fire && (i_rx_data != hdr_cur);
        o_err_crc     = (state == ST_RX_HDR) && rx_fire && (idx == HDR_LAST) && (bad_q || hdr_miss);
        o_err_timeout = timeout;
        o_wb_ack      = (state == ST_ACK) && !drop_q && i_wb_cyc;

        state_nx = state;
        unique case (state)
            ST_IDLE:    if (i_wb_cyc && i_wb_stb) state_nx = ST_TX_HDR;
            ST_TX_HDR:  if (tx_fire && idx == HDR_LAST) state_nx = we_q ? ST_TX_DATA : ST_RX_HDR;
            ST_TX_DATA: if (tx_fire && idx == DATA_LAST) state_nx = ST_RX_HDR;
            ST_RX_HDR: begin
                if (timeout) state_nx = ST_ACK;
                else if (rx_fire && idx == HDR_LAST) state_nx = we_q ? ST_ACK : ST_RX_DATA;
            end
            ST_RX_DATA: begin
                if (timeout) state_nx = ST_ACK;
                else if (rx_fire && idx == DATA_LAST) state_nx = ST_ACK;
            end
            ST_ACK:     state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            crc_q     <= '0;
            bad_q     <= 1'b0;
            drop_q    <= 1'b0;
            tmo_cnt   <= '0;
            o_wb_data <= '0;
        end else begin
            state <= state_nx;

            if (state_nx != state) idx <= '0;
            else if (tx_fire || rx_fire) idx <= idx + 3'd1;

            if (state == ST_IDLE && i_wb_cyc && i_wb_stb) begin
                we_q    <= i_wb_we;
                addr_q  <= i_wb_addr;
                wdata_q <= i_wb_data;
                crc_q   <= '0;
                bad_q   <= 1'b0;
                drop_q  <= 1'b0;
            end else begin
                if (state == ST_TX_HDR && tx_fire && idx != HDR_LAST) crc_q <= crc_nx;
                if (hdr_miss) bad_q <= 1'b1;
                if (state != ST_IDLE && !i_wb_cyc) drop_q <= 1'b1;
            end

            if (!rx_state || rx_fire) tmo_cnt <= '0;
            else tmo_cnt <= tmo_cnt + 16'd1;

            if (timeout) o_wb_data <= ERR_DATA;
            else if (state == ST_RX_DATA && rx_fire)
                o_wb_data[{idx[1:0], 3'b000} +: 8] <= bad_q ? 8'hFF : i_rx_data;
        end
    end

endmodule

// File: tb/tb_wb_ctrl_client.sv
// Directed bench for wb_ctrl_client: drives Wishbone requests, plays the far end
// of the byte link, and checks frames, latency, data and error pulses.
module tb_wb_ctrl_client;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_addr;
    logic [31:0] wb_wdata;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, o_rx_ready;
    logic        o_err_crc, o_err_timeout;

    always #5 clk = ~clk;

    wb_ctrl_client #(.WB_ADDR_WIDTH(30), .TIMEOUT_CYCLES(20)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wb_cyc      (wb_cyc),
        .i_wb_stb      (wb_stb),
        .i_wb_we       (wb_we),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_wdata),
        .i_wb_sel      (4'hF),
        .o_wb_stall    (o_wb_stall),
        .o_wb_ack      (o_wb_ack),
        .o_wb_data     (o_wb_data),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (tx_ready),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_rx_ready    (o_rx_ready),
        .o_err_crc     (o_err_crc),
        .o_err_timeout (o_err_timeout)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  resp_q[$];
    logic        got_ack, done;
    logic [31:0] ack_data;
    int          ack_lat, n_crc, n_tmo, t0, t_last_tx, t_tmo;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: feed each message bit into the CRC register
    function automatic logic [7:0] ref_crc(input logic [47:0] msg);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 6; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ msg[8*i + j];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // mode: 0 normal echo, 1 corrupt echoed CRC, 2 no response, 3 drop cyc in RX_HDR
    task automatic run_txn(input logic we, input logic [29:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int mode, input bit bp);
        logic [7:0]  hb[7];
        logic [31:0] a32;
        a32   = {2'b00, addr};
        hb[0] = we ? 8'hD0 : 8'h50;
        hb[1] = 8'h00;
        hb[2] = a32[7:0];
        hb[3] = a32[15:8];
        hb[4] = a32[23:16];
        hb[5] = a32[31:24];
        hb[6] = ref_crc({a32, 8'h00, hb[0]});
        tx_q.delete();
        exp_q.delete();
        resp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(hb[i]);
        if (we) for (int i = 0; i < 4; i++) exp_q.push_back(wdata[8*i +: 8]);
        if (mode != 2) begin
            for (int i = 0; i < 7; i++) resp_q.push_back((mode == 1 && i == 6) ? (hb[i] ^ 8'h01) : hb[i]);
            if (!we) for (int i = 0; i < 4; i++) resp_q.push_back(rdata[8*i +: 8]);
        end
        got_ack = 1'b0; ack_data = '0; ack_lat = -1;
        n_crc = 0; n_tmo = 0; t_last_tx = -1; t_tmo = -1; done = 1'b0;

        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
        #1;
        chk("stall_before_req", 96'(o_wb_stall), 96'(0));
        t0 = cycle;
        @(negedge clk);
        wb_stb = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!o_wb_stall) begin
                done = 1'b1;
                break;
            end
            tx_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (resp_q.size() > 0) begin
                rx_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                rx_data  = resp_q[0];
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
            if (mode == 3 && o_rx_ready) wb_cyc = 1'b0;
            #1;
            if (o_tx_valid && tx_ready) begin
                tx_q.push_back(o_tx_data);
                t_last_tx = cycle;
            end
            if (o_rx_ready && rx_valid) void'(resp_q.pop_front());
            if (o_wb_ack) begin
                got_ack  = 1'b1;
                ack_data = o_wb_data;
                ack_lat  = cycle - t0;
            end
            if (o_err_crc) n_crc++;
            if (o_err_timeout) begin
                n_tmo++;
                t_tmo = cycle;
            end
            @(negedge clk);
        end
        wb_cyc = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        chk("frame_complete", 96'(done), 96'(1));
    endtask

    task automatic check_frame(input string tag);
        logic [95:0] o, e;
        o = '0;
        e = '0;
        foreach (tx_q[i]) if (i < 12) o[8*i +: 8] = tx_q[i];
        foreach (exp_q[i]) if (i < 12) e[8*i +: 8] = exp_q[i];
        chk({tag, "_tx_len"}, 96'(tx_q.size()), 96'(exp_q.size()));
        chk({tag, "_tx_bytes"}, o, e);
    endtask

    initial begin
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 96'(o_wb_stall), 96'(0));
        chk("rst_ack", 96'(o_wb_ack), 96'(0));
        chk("rst_tx_valid", 96'(o_tx_valid), 96'(0));
        chk("rst_rx_ready", 96'(o_rx_ready), 96'(0));
        chk("rst_err", 96'({o_err_crc, o_err_timeout}), 96'(0));
        chk("rst_wb_data", 96'(o_wb_data), 96'(0));

        // Write with both streams always ready
        run_txn(1'b1, 30'h10, 32'hA5A5_1234, 32'h0, 0, 1'b0);
        check_frame("wr");
        chk("wr_b0", 96'(tx_q[0]), 96'(8'hD0));
        chk("wr_data_bytes", 96'({tx_q[10], tx_q[9], tx_q[8], tx_q[7]}), 96'(32'hA5A5_1234));
        chk("wr_ack", 96'(got_ack), 96'(1));
        chk("wr_ack_lat", 96'(ack_lat), 96'(19));
        chk("wr_last_tx", 96'(t_last_tx - t0), 96'(11));
        chk("wr_no_err", 96'(n_crc + n_tmo), 96'(0));

        // Read from the top word address
        run_txn(1'b0, 30'h3FFF_FFFF, 32'h0, 32'h1234_5678, 0, 1'b0);
        check_frame("rd");
        chk("rd_b0", 96'(tx_q[0]), 96'(8'h50));
        chk("rd_addr_bytes", 96'({tx_q[2], tx_q[3], tx_q[4], tx_q[5]}), 96'(32'hFFFF_FF3F));
        chk("rd_ack", 96'(got_ack), 96'(1));
        chk("rd_data", 96'(ack_data), 96'(32'h1234_5678));
        chk("rd_ack_lat", 96'(ack_lat), 96'(19));
        chk("rd_last_tx", 96'(t_last_tx - t0), 96'(7));

        // Mixed accesses under random backpressure on both streams
        for (int n = 0; n < 100; n++) begin
            logic        we;
            logic [31:0] wd, rd, ad;
            we = 1'($urandom_range(0, 1));
            ad = $urandom;
            wd = $urandom;
            rd = $urandom;
            run_txn(we, ad[29:0], wd, rd, 0, 1'b1);
            check_frame("rnd");
            chk("rnd_ack", 96'(got_ack), 96'(1));
            chk("rnd_no_err", 96'(n_crc + n_tmo), 96'(0));
            chk("rnd_rx_consumed", 96'(resp_q.size()), 96'(0));
            if (!we) chk("rnd_rd_data", 96'(ack_data), 96'(rd));
        end

        // Corrupted echoed CRC on a read
        run_txn(1'b0, 30'h0000_0ABC, 32'h0, 32'hCAFE_BABE, 1, 1'b0);
        chk("crc_pulses", 96'(n_crc), 96'(1));
        chk("crc_rx_consumed", 96'(resp_q.size()), 96'(0));
        chk("crc_ack", 96'(got_ack), 96'(1));
        chk("crc_data", 96'(ack_data), 96'(32'hFFFF_FFFF));

        // No response at all: timeout 20 cycles after the last command byte
        run_txn(1'b0, 30'h0000_0040, 32'h0, 32'h0, 2, 1'b0);
        chk("tmo_pulses", 96'(n_tmo), 96'(1));
        chk("tmo_delay", 96'(t_tmo - t_last_tx), 96'(20));
        chk("tmo_ack", 96'(got_ack), 96'(1));
        chk("tmo_data", 96'(ack_data), 96'(32'hFFFF_FFFF));
        run_txn(1'b1, 30'h0000_0044, 32'h0102_0304, 32'h0, 0, 1'b0);
        check_frame("post_tmo");
        chk("post_tmo_ack_lat", 96'(ack_lat), 96'(19));
        chk("post_tmo_no_err", 96'(n_tmo + n_crc), 96'(0));
        chk("wr_holds_rdata", 96'(o_wb_data), 96'(32'hFFFF_FFFF));

        // Master abandons the cycle during the response header
        run_txn(1'b1, 30'h0000_0123, 32'h5555_AAAA, 32'h0, 3, 1'b0);
        check_frame("drop");
        chk("drop_no_ack", 96'(got_ack), 96'(0));
        chk("drop_rx_consumed", 96'(resp_q.size()), 96'(0));

        // Reset while the write data is going out
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 30'h5; wb_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        wb_stb = 1'b0; tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("rstmid_tx_valid", 96'(o_tx_valid), 96'(1));
        chk("rstmid_tx_byte1", 96'(o_tx_data), 96'(8'hF0));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_stall", 96'(o_wb_stall), 96'(0));
        chk("rstmid_tx_valid0", 96'(o_tx_valid), 96'(0));
        chk("rstmid_rx_ready", 96'(o_rx_ready), 96'(0));
        chk("rstmid_ack", 96'(o_wb_ack), 96'(0));
        chk("rstmid_wb_data", 96'(o_wb_data), 96'(0));
        rst = 1'b0; wb_cyc = 1'b0; tx_ready = 1'b0;

        run_txn(1'b0, 30'h0000_0200, 32'h0, 32'h89AB_CDEF, 0, 1'b0);
        check_frame("post_rst");
        chk("post_rst_data", 96'(ack_data), 96'(32'h89AB_CDEF));
        chk("post_rst_ack_lat", 96'(ack_lat), 96'(19));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
